// File: rtl/bus_master_ctrl_pkg.sv
// Shared types and bus-level constants for the master-side bus sequencer.
package bus_master_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_ACCESS = 2'd2,
        ST_WAIT   = 2'd3
    } mst_state_e;

    localparam logic BUS_READ     = 1'b1;
    localparam logic BUS_WRITE    = 1'b0;
    localparam logic BUS_ENABLE_  = 1'b0;
    localparam logic BUS_DISABLE_ = 1'b1;

endpackage

// File: rtl/bus_master_ctrl_if.sv
// Client-side request port plus arbiter/bus signals of one bus master.
interface bus_master_ctrl_if #(
    parameter int ADDR_W = 30,
    parameter int DATA_W = 32
);
    logic              cl_req;
    logic              cl_rw;
    logic [ADDR_W-1:0] cl_addr;
    logic [DATA_W-1:0] cl_wr_data;
    logic              cl_ack;
    logic              cl_err;
    logic [DATA_W-1:0] cl_rd_data;
    logic              busy;
    logic              m_req_;
    logic              m_grnt_;
    logic              m_as_;
    logic              m_rw;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_wr_data;
    logic [DATA_W-1:0] s_rd_data;
    logic              s_rdy_;

    modport master (
        input  cl_req, cl_rw, cl_addr, cl_wr_data, m_grnt_, s_rd_data, s_rdy_,
        output cl_ack, cl_err, cl_rd_data, busy, m_req_, m_as_, m_rw, m_addr, m_wr_data
    );

    modport slave (
        output cl_req, cl_rw, cl_addr, cl_wr_data, m_grnt_, s_rd_data, s_rdy_,
        input  cl_ack, cl_err, cl_rd_data, busy, m_req_, m_as_, m_rw, m_addr, m_wr_data
    );
endinterface

// File: rtl/bus_master_ctrl_timeout_cnt.sv
// Slave-response timeout counter: cleared at access start, counts wait cycles.
module bus_master_ctrl_timeout_cnt #(
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic hit
);
    logic [TO_W-1:0] cnt_r;

    // Wait-cycle counter
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (clr) begin
            cnt_r <= {TO_W{1'b0}};
        end else if (en) begin
            cnt_r <= cnt_r + {{(TO_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // The wait cycle holding TIMEOUT-1 is the last one allowed, so the
    // limit is reached exactly TIMEOUT cycles after the strobe.
    assign hit = (cnt_r == TO_W'(TIMEOUT - 1));
endmodule

// File: rtl/bus_master_ctrl.sv
// Master-side bus access sequencer: client request -> req_/grnt_/as_/rdy_
// handshake, with slave-response timeout and grant-loss error reporting.
module bus_master_ctrl
    import bus_master_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 30,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 255,
    parameter int TO_W    = 8
) (
    input logic               clk,
    input logic               reset,
    bus_master_ctrl_if.master bus
);
    mst_state_e        state_r, state_s;
    logic              lat_rw_r, lat_rw_s;
    logic [ADDR_W-1:0] lat_addr_r, lat_addr_s;
    logic [DATA_W-1:0] lat_wr_data_r, lat_wr_data_s;
    logic              req_s, as_s, rw_s, ack_s, err_s, busy_s;
    logic [ADDR_W-1:0] addr_s;
    logic [DATA_W-1:0] wr_data_s, rd_data_s;
    logic              cnt_clr_s, cnt_en_s, to_hit_s, done_s, fail_s;

    bus_master_ctrl_timeout_cnt #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_timeout (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr_s),
        .en    (cnt_en_s),
        .hit   (to_hit_s)
    );

    // Next-state and next-output decode
    always_comb begin
        state_s       = state_r;
        lat_rw_s      = lat_rw_r;
        lat_addr_s    = lat_addr_r;
        lat_wr_data_s = lat_wr_data_r;
        req_s         = bus.m_req_;
        as_s          = BUS_DISABLE_;
        rw_s          = bus.m_rw;
        addr_s        = bus.m_addr;
        wr_data_s     = bus.m_wr_data;
        rd_data_s     = bus.cl_rd_data;
        ack_s         = 1'b0;
        err_s         = 1'b0;
        cnt_clr_s     = 1'b0;
        cnt_en_s      = 1'b0;
        done_s        = 1'b0;
        fail_s        = 1'b0;

        case (state_r)
            ST_IDLE: begin
                if (bus.cl_req) begin
                    lat_rw_s      = bus.cl_rw;
                    lat_addr_s    = bus.cl_addr;
                    lat_wr_data_s = bus.cl_wr_data;
                    req_s         = BUS_ENABLE_;
                    state_s       = ST_REQ;
                end else begin
                    req_s = BUS_DISABLE_;
                end
            end
            ST_REQ: begin
                if (bus.m_grnt_ == BUS_ENABLE_) begin
                    as_s      = BUS_ENABLE_;
                    rw_s      = lat_rw_r;
                    addr_s    = lat_addr_r;
                    wr_data_s = lat_wr_data_r;
                    cnt_clr_s = 1'b1;
                    state_s   = ST_ACCESS;
                end else begin
                    state_s = ST_REQ;
                end
            end
            ST_ACCESS: begin
                if (bus.s_rdy_ == BUS_ENABLE_) begin
                    done_s = 1'b1;
                end else if (bus.m_grnt_ == BUS_DISABLE_) begin
                    done_s = 1'b1;
                    fail_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            ST_WAIT: begin
                // ready beats grant loss, grant loss beats timeout
                cnt_en_s = 1'b1;
                if (bus.s_rdy_ == BUS_ENABLE_) begin
                    done_s = 1'b1;
                end else if (bus.m_grnt_ == BUS_DISABLE_) begin
                    done_s = 1'b1;
                    fail_s = 1'b1;
                end else if (to_hit_s) begin
                    done_s = 1'b1;
                    fail_s = 1'b1;
                end else begin
                    state_s = ST_WAIT;
                end
            end
            default: begin
                req_s   = BUS_DISABLE_;
                state_s = ST_IDLE;
            end
        endcase

        if (done_s) begin
            ack_s     = 1'b1;
            err_s     = fail_s;
            rd_data_s = (!fail_s && (bus.m_rw == BUS_READ)) ? bus.s_rd_data : {DATA_W{1'b0}};
            req_s     = BUS_DISABLE_;
            state_s   = ST_IDLE;
        end else begin
            ack_s = 1'b0;
        end

        busy_s = (state_s != ST_IDLE);
    end

    // State, latched request and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            lat_rw_r       <= BUS_READ;
            lat_addr_r     <= {ADDR_W{1'b0}};
            lat_wr_data_r  <= {DATA_W{1'b0}};
            bus.m_req_     <= BUS_DISABLE_;
            bus.m_as_      <= BUS_DISABLE_;
            bus.m_rw       <= BUS_READ;
            bus.m_addr     <= {ADDR_W{1'b0}};
            bus.m_wr_data  <= {DATA_W{1'b0}};
            bus.cl_ack     <= 1'b0;
            bus.cl_err     <= 1'b0;
            bus.cl_rd_data <= {DATA_W{1'b0}};
            bus.busy       <= 1'b0;
        end else begin
            state_r        <= state_s;
            lat_rw_r       <= lat_rw_s;
            lat_addr_r     <= lat_addr_s;
            lat_wr_data_r  <= lat_wr_data_s;
            bus.m_req_     <= req_s;
            bus.m_as_      <= as_s;
            bus.m_rw       <= rw_s;
            bus.m_addr     <= addr_s;
            bus.m_wr_data  <= wr_data_s;
            bus.cl_ack     <= ack_s;
            bus.cl_err     <= err_s;
            bus.cl_rd_data <= rd_data_s;
            bus.busy       <= busy_s;
        end
    end
endmodule
